// File: rtl/bayer_frame_source_if.sv
// Raw-Bayer pixel stream bundle between the synthetic frame source and its consumer.
// oDVAL qualifies oDATA/oX_Cont each cycle with no back-pressure; the consumer must accept every valid pixel.
interface bayer_frame_source_if;
   logic        iStart;
   logic        iStop;
   logic [1:0]  iMode;
   logic [11:0] iConst;
   logic [11:0] oDATA;
   logic        oDVAL;
   logic [10:0] oX_Cont;
   logic [10:0] oY_Cont;
   logic        oFVAL;
   logic [15:0] oFrame_Cont;
   logic        oBusy;
   logic [1:0]  dbg_state;

   modport master (
      input  iStart, iStop, iMode, iConst,
      output oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL, oFrame_Cont, oBusy, dbg_state
   );

   modport slave (
      output iStart, iStop, iMode, iConst,
      input  oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL, oFrame_Cont, oBusy, dbg_state
   );
endinterface

// File: rtl/bayer_frame_source.sv
// Synthetic 12-bit Bayer frame generator with sensor-style line/frame blanking.
// Every output is a register fed from the current FSM state and counters.
module bayer_frame_source #(
   parameter int H_ACTIVE = 1280,
   parameter int V_ACTIVE = 960,
   parameter int H_BLANK  = 64,
   parameter int V_BLANK  = 16
) (
   input logic                  iCLK,
   input logic                  iRST,
   bayer_frame_source_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HBLANK = 2'd2,
      S_VBLANK = 2'd3
   } state_t;

   localparam logic [10:0] X_LAST  = 11'(H_ACTIVE - 1);
   localparam logic [10:0] Y_LAST  = 11'(V_ACTIVE - 1);
   localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
   localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);

   state_t      state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [15:0] bcnt_q, bcnt_d;
   logic        stop_q, stop_d;
   logic [1:0]  mode_q, mode_d;
   logic [11:0] const_q, const_d;
   logic        frame_done;

   logic [11:0] data_q, data_d;
   logic        dval_q, dval_d;
   logic [10:0] xo_q, xo_d;
   logic [10:0] yo_q, yo_d;
   logic        fval_q, fval_d;
   logic [15:0] frame_q, frame_d;
   logic        busy_q, busy_d;

   logic [11:0] pixel;

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         bcnt_q  <= '0;
         stop_q  <= 1'b0;
         mode_q  <= '0;
         const_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         bcnt_q  <= bcnt_d;
         stop_q  <= stop_d;
         mode_q  <= mode_d;
         const_q <= const_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      bcnt_d     = bcnt_q;
      stop_d     = stop_q;
      mode_d     = mode_q;
      const_d    = const_q;
      frame_done = 1'b0;

      // A stop seen while busy is remembered until the frame boundary.
      if (state_q != S_IDLE && bus.iStop) begin
         stop_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.iStart) begin
               state_d = S_ACTIVE;
               x_d     = '0;
               y_d     = '0;
               mode_d  = bus.iMode;
               const_d = bus.iConst;
               stop_d  = bus.iStop;
            end
         end
         S_ACTIVE: begin
            if (x_q == X_LAST) begin
               state_d = S_HBLANK;
               bcnt_d  = '0;
            end else begin
               x_d = x_q + 11'd1;
            end
         end
         S_HBLANK: begin
            if (bcnt_q == HB_LAST) begin
               if (y_q < Y_LAST) begin
                  state_d = S_ACTIVE;
                  x_d     = '0;
                  y_d     = y_q + 11'd1;
               end else begin
                  state_d = S_VBLANK;
                  bcnt_d  = '0;
               end
            end else begin
               bcnt_d = bcnt_q + 16'd1;
            end
         end
         S_VBLANK: begin
            if (bcnt_q == VB_LAST) begin
               frame_done = 1'b1;
               if (stop_d) begin
                  state_d = S_IDLE;
                  stop_d  = 1'b0;
               end else begin
                  state_d = S_ACTIVE;
                  x_d     = '0;
                  y_d     = '0;
                  mode_d  = bus.iMode;
                  const_d = bus.iConst;
               end
            end else begin
               bcnt_d = bcnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Pattern generator works on the coordinates held in the state registers.
   always_comb begin
      pixel = '0;
      case (mode_q)
         2'd0: pixel = {1'b0, x_q} + {1'b0, y_q};
         2'd1: pixel = (x_q[3] ^ y_q[3]) ? 12'hFFF : 12'h000;
         2'd2: begin
            if (x_q[0] == y_q[0]) begin
               pixel = 12'h800;
            end else if (!y_q[0]) begin
               pixel = 12'hFFF;
            end else begin
               pixel = 12'h040;
            end
         end
         default: pixel = const_q;
      endcase
   end

   always_comb begin
      dval_d  = (state_q == S_ACTIVE);
      data_d  = dval_d ? pixel : 12'h000;
      xo_d    = dval_d ? x_q : 11'd0;
      fval_d  = (state_q == S_ACTIVE) || (state_q == S_HBLANK);
      yo_d    = fval_d ? y_q : 11'd0;
      busy_d  = (state_q != S_IDLE);
      frame_d = frame_q + {15'd0, frame_done};
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         data_q  <= '0;
         dval_q  <= 1'b0;
         xo_q    <= '0;
         yo_q    <= '0;
         fval_q  <= 1'b0;
         frame_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         data_q  <= data_d;
         dval_q  <= dval_d;
         xo_q    <= xo_d;
         yo_q    <= yo_d;
         fval_q  <= fval_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.oDATA       = data_q;
   assign bus.oDVAL       = dval_q;
   assign bus.oX_Cont     = xo_q;
   assign bus.oY_Cont     = yo_q;
   assign bus.oFVAL       = fval_q;
   assign bus.oFrame_Cont = frame_q;
   assign bus.oBusy       = busy_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_bayer_frame_source.sv
// Scenario bench for bayer_frame_source using a frame-timeline reference model.
// Each frame is modelled as a 49-cycle timeline indexed from the first active pixel.
module tb_bayer_frame_source;

   localparam int H        = 8;
   localparam int V        = 4;
   localparam int HB       = 3;
   localparam int VB       = 5;
   localparam int LINE     = H + HB;
   localparam int FVAL_CYC = LINE * V;
   localparam int PERIOD   = FVAL_CYC + VB;

   typedef struct packed {
      logic        dval;
      logic [11:0] data;
      logic [10:0] x;
      logic [10:0] y;
      logic        fval;
      logic        busy;
      logic [15:0] fc;
   } obs_t;

   logic iCLK = 1'b0;
   logic iRST;
   int   vectors = 0;
   int   miscompares = 0;

   bayer_frame_source_if bus ();

   bayer_frame_source #(
      .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB)
   ) dut (
      .iCLK(iCLK),
      .iRST(iRST),
      .bus (bus.master)
   );

   always #5 iCLK = ~iCLK;

   function automatic logic [11:0] ref_pixel(int mode, int cst, int x, int y);
      case (mode)
         0: return 12'((x + y) % 4096);
         1: return (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
         2: begin
            if ((x % 2) == (y % 2)) return 12'h800;
            else if ((y % 2) == 0)  return 12'hFFF;
            else                    return 12'h040;
         end
         default: return 12'(cst);
      endcase
   endfunction

   // Expected outputs t cycles after the first pixel of a frame.
   function automatic obs_t ref_out(int t, int mode, int cst, int frames_before);
      obs_t e;
      int   line;
      int   col;
      e = '0;
      line = t / LINE;
      col = t % LINE;
      e.busy = 1'b1;
      e.fc = 16'(frames_before + ((t == PERIOD - 1) ? 1 : 0));
      if (t < FVAL_CYC) begin
         e.fval = 1'b1;
         e.y = 11'(line);
         if (col < H) begin
            e.dval = 1'b1;
            e.x = 11'(col);
            e.data = ref_pixel(mode, cst, col, line);
         end
      end
      return e;
   endfunction

   function automatic obs_t idle_out(int frames);
      obs_t e;
      e = '0;
      e.fc = 16'(frames);
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t s;
      s.dval = bus.oDVAL;
      s.data = bus.oDATA;
      s.x    = bus.oX_Cont;
      s.y    = bus.oY_Cont;
      s.fval = bus.oFVAL;
      s.busy = bus.oBusy;
      s.fc   = bus.oFrame_Cont;
      return s;
   endfunction

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic apply_reset();
      iRST = 1'b0;
      bus.iStart = 1'b0;
      bus.iStop = 1'b0;
      bus.iMode = 2'd0;
      bus.iConst = 12'd0;
      repeat (2) tick();
      iRST = 1'b1;
      tick();
   endtask

   // Start edge k; afterwards the bench sits #1 after edge k, with outputs still idle.
   task automatic start_frame(int mode, int cst, logic stop);
      bus.iStart = 1'b1;
      bus.iStop = stop;
      bus.iMode = 2'(mode);
      bus.iConst = 12'(cst);
      tick();
      bus.iStart = 1'b0;
      bus.iStop = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got;
      iRST = 1'b0;
      bus.iStart = 1'b1;
      bus.iStop = 1'b0;
      bus.iMode = 2'd3;
      bus.iConst = 12'h123;
      repeat (3) tick();
      got = sample();
      vectors++;
      if (got !== idle_out(0)) begin
         miscompares++;
         $display("FAIL reset_outputs got %h exp %h", got, idle_out(0));
      end
      bus.iStart = 1'b0;
      iRST = 1'b1;
      repeat (4) tick();
      got = sample();
      vectors++;
      if (got !== idle_out(0)) begin
         miscompares++;
         $display("FAIL reset_no_autostart got %h exp %h", got, idle_out(0));
      end
   endtask

   task automatic test_ramp_first_frame();
      obs_t got, exp;
      apply_reset();
      start_frame(0, 0, 1'b0);
      got = sample();
      vectors++;
      if (got !== idle_out(0)) begin
         miscompares++;
         $display("FAIL ramp_latency got %h exp %h", got, idle_out(0));
      end
      for (int t = 0; t < PERIOD; t++) begin
         tick();
         got = sample();
         exp = ref_out(t, 0, 0, 0);
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL ramp_frame t=%0d got %h exp %h", t, got, exp);
         end
      end
   endtask

   task automatic test_const_free_run();
      obs_t got, exp;
      int   pix;
      int   fval_low;
      apply_reset();
      start_frame(3, 12'hABC, 1'b0);
      for (int f = 0; f < 3; f++) begin
         pix = 0;
         fval_low = 0;
         for (int t = 0; t < PERIOD; t++) begin
            tick();
            got = sample();
            exp = ref_out(t, 3, 12'hABC, f);
            if (got.dval) pix++;
            if (!got.fval) fval_low++;
            vectors++;
            if (got !== exp) begin
               miscompares++;
               $display("FAIL const_frame f=%0d t=%0d got %h exp %h", f, t, got, exp);
            end
         end
         vectors++;
         if (pix != H * V) begin
            miscompares++;
            $display("FAIL const_pixel_count f=%0d got %0d exp %0d", f, pix, H * V);
         end
         vectors++;
         if (fval_low != VB) begin
            miscompares++;
            $display("FAIL const_fval_gap f=%0d got %0d exp %0d", f, fval_low, VB);
         end
      end
   endtask

   task automatic test_mode_change();
      obs_t got, exp;
      int   probe_t[4];
      logic [11:0] probe_v[4];
      probe_t = '{0, 1, LINE, LINE + 1};
      probe_v = '{12'h800, 12'hFFF, 12'h040, 12'h800};
      apply_reset();
      start_frame(0, 0, 1'b0);
      for (int f = 0; f < 2; f++) begin
         for (int t = 0; t < PERIOD; t++) begin
            tick();
            if (f == 0 && t == 20) bus.iMode = 2'd2;
            got = sample();
            exp = ref_out(t, (f == 0) ? 0 : 2, 0, f);
            vectors++;
            if (got !== exp) begin
               miscompares++;
               $display("FAIL mode_change f=%0d t=%0d got %h exp %h", f, t, got, exp);
            end
            for (int p = 0; p < 4; p++) begin
               if (f == 1 && t == probe_t[p]) begin
                  vectors++;
                  if (got.data !== probe_v[p]) begin
                     miscompares++;
                     $display("FAIL bayer_site t=%0d got %h exp %h", t, got.data, probe_v[p]);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_stop();
      obs_t got, exp;
      apply_reset();
      start_frame(1, 0, 1'b0);
      for (int f = 0; f < 2; f++) begin
         for (int t = 0; t < PERIOD; t++) begin
            tick();
            bus.iStop = (f == 1 && t == 25);
            bus.iStart = (t == 30 || t == 47);
            got = sample();
            exp = ref_out(t, 1, 0, f);
            vectors++;
            if (got !== exp) begin
               miscompares++;
               $display("FAIL stop_frame f=%0d t=%0d got %h exp %h", f, t, got, exp);
            end
         end
      end
      bus.iStart = 1'b0;
      bus.iStop = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         got = sample();
         vectors++;
         if (got !== idle_out(2)) begin
            miscompares++;
            $display("FAIL stop_idle i=%0d got %h exp %h", i, got, idle_out(2));
         end
      end
      start_frame(1, 0, 1'b0);
      tick();
      got = sample();
      exp = ref_out(0, 1, 0, 2);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL stop_restart got %h exp %h", got, exp);
      end
   endtask

   task automatic test_start_stop_same();
      obs_t got, exp;
      int   pix;
      pix = 0;
      apply_reset();
      start_frame(2, 0, 1'b1);
      for (int t = 0; t < PERIOD + 15; t++) begin
         tick();
         got = sample();
         exp = (t < PERIOD) ? ref_out(t, 2, 0, 0) : idle_out(1);
         if (got.dval) pix++;
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL one_shot t=%0d got %h exp %h", t, got, exp);
         end
      end
      vectors++;
      if (pix != H * V) begin
         miscompares++;
         $display("FAIL one_shot_count got %0d exp %0d", pix, H * V);
      end
   endtask

   task automatic test_async_reset();
      obs_t got, exp;
      apply_reset();
      start_frame(0, 0, 1'b0);
      for (int t = 0; t < 15; t++) begin
         tick();
         got = sample();
         exp = ref_out(t, 0, 0, 0);
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL pre_reset t=%0d got %h exp %h", t, got, exp);
         end
      end
      #2;
      iRST = 1'b0;
      #1;
      got = sample();
      vectors++;
      if (got !== idle_out(0)) begin
         miscompares++;
         $display("FAIL async_reset got %h exp %h", got, idle_out(0));
      end
      tick();
      iRST = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         got = sample();
         vectors++;
         if (got !== idle_out(0)) begin
            miscompares++;
            $display("FAIL post_reset_idle i=%0d got %h exp %h", i, got, idle_out(0));
         end
      end
      start_frame(0, 0, 1'b0);
      for (int t = 0; t < LINE; t++) begin
         tick();
         got = sample();
         exp = ref_out(t, 0, 0, 0);
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL post_reset_start t=%0d got %h exp %h", t, got, exp);
         end
      end
   endtask

   // Mode/const inputs toggle every cycle; only the values present at frame start may matter.
   task automatic test_random();
      obs_t got, exp;
      int   cur_m, cur_c, nxt_m, nxt_c, stop_t;
      for (int r = 0; r < 4; r++) begin
         apply_reset();
         cur_m = $urandom_range(0, 3);
         cur_c = $urandom_range(0, 4095);
         nxt_m = cur_m;
         nxt_c = cur_c;
         stop_t = $urandom_range(0, 44);
         start_frame(cur_m, cur_c, 1'b0);
         for (int f = 0; f < 3; f++) begin
            for (int t = 0; t < PERIOD; t++) begin
               tick();
               bus.iMode = 2'($urandom_range(0, 3));
               bus.iConst = 12'($urandom_range(0, 4095));
               bus.iStart = 1'($urandom_range(0, 1));
               bus.iStop = (f == 2 && t == stop_t);
               if (t == PERIOD - 2) begin
                  nxt_m = int'(bus.iMode);
                  nxt_c = int'(bus.iConst);
               end
               got = sample();
               exp = ref_out(t, cur_m, cur_c, f);
               vectors++;
               if (got !== exp) begin
                  miscompares++;
                  $display("FAIL random r=%0d f=%0d t=%0d got %h exp %h", r, f, t, got, exp);
               end
            end
            cur_m = nxt_m;
            cur_c = nxt_c;
         end
         bus.iStart = 1'b0;
         bus.iStop = 1'b0;
         for (int i = 0; i < 4; i++) begin
            tick();
            got = sample();
            vectors++;
            if (got !== idle_out(3)) begin
               miscompares++;
               $display("FAIL random_stop r=%0d i=%0d got %h exp %h", r, i, got, idle_out(3));
            end
         end
      end
   endtask

   initial begin
      iRST = 1'b0;
      bus.iStart = 1'b0;
      bus.iStop = 1'b0;
      bus.iMode = 2'd0;
      bus.iConst = 12'd0;
      test_reset();
      test_ramp_first_frame();
      test_const_free_run();
      test_mode_change();
      test_stop();
      test_start_stop_same();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
